// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the UART transmit message sequencer.
// TX_CHECKSUM_EN selects the 11-byte frame with a trailing XOR checksum.
package tx_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_seq_state_e;

  localparam int PREFIX_LEN = 5;
  localparam logic [7:0] PREFIX_0 = 8'h44;  // 'D'
  localparam logic [7:0] PREFIX_1 = 8'h41;  // 'A'
  localparam logic [7:0] PREFIX_2 = 8'h54;  // 'T'
  localparam logic [7:0] PREFIX_3 = 8'h41;  // 'A'
  localparam logic [7:0] PREFIX_4 = 8'h3A;  // ':'
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int FRAME_LEN_BASE  = 9;
  localparam int FRAME_LEN_CKSUM = 11;

  // 'A'..'F' sit at 0x41, so 0x41 + (n - 10) folds to 0x37 + n.
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw push-button and emits one pulse per
// accepted press; BTN_ACTIVE_LOW selects which raw level means pressed.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic RELEASED_RAW = (BTN_ACTIVE_LOW != 0);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          pressed_sync;
  logic [CW-1:0] cnt;

  assign pressed_sync = sync_2 ^ RELEASED_RAW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1      <= RELEASED_RAW;
      sync_2      <= RELEASED_RAW;
      level       <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= btn;
      sync_2      <= sync_1;
      press_pulse <= 1'b0;
      // Level flips only after a full run of disagreeing samples.
      if (pressed_sync != level) begin
        if (cnt == CNT_LAST) begin
          level       <= pressed_sync;
          cnt         <= '0;
          press_pulse <= pressed_sync;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tx_message_sequencer.sv
// Streams "DATA:<hex>\r\n" into the UART TX FIFO on each debounced press.
// Define TX_CHECKSUM_EN to append two hex XOR-checksum characters before CR LF.
module tx_message_sequencer
  import tx_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  btn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tx_fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_wr_en,
  output logic                  busy,
  output logic                  msg_done,
  output tx_seq_state_e         state_dbg
);

`ifdef TX_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  tx_seq_state_e         state;
  logic [3:0]            idx;
  logic [DATA_WIDTH-1:0] cap;
  logic [7:0]            frame_byte;
  logic                  press_pulse;
`ifdef TX_CHECKSUM_EN
  logic [7:0]            cksum;
`endif

  assign state_dbg = state;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_debouncer (
    .clk        (CLK),
    .rst_n      (RST),
    .btn        (btn),
    .press_pulse(press_pulse)
  );

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      4'd0: frame_byte = PREFIX_0;
      4'd1: frame_byte = PREFIX_1;
      4'd2: frame_byte = PREFIX_2;
      4'd3: frame_byte = PREFIX_3;
      4'd4: frame_byte = PREFIX_4;
      4'd5: frame_byte = nibble_to_hex(cap[7:4]);
      4'd6: frame_byte = nibble_to_hex(cap[3:0]);
`ifdef TX_CHECKSUM_EN
      4'd7: frame_byte = nibble_to_hex(cksum[7:4]);
      4'd8: frame_byte = nibble_to_hex(cksum[3:0]);
      4'd9: frame_byte = ASCII_CR;
      4'd10: frame_byte = ASCII_LF;
`else
      4'd7: frame_byte = ASCII_CR;
      4'd8: frame_byte = ASCII_LF;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  // Handshake: a byte is transferred in every cycle where fifo_wr_en=1; a new
  // write is only issued when the FIFO reported not-full and no write is in
  // flight, so the full flag always has one cycle to react to the last byte.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cap        <= '0;
      fifo_data  <= '0;
      fifo_wr_en <= 1'b0;
      busy       <= 1'b0;
      msg_done   <= 1'b0;
`ifdef TX_CHECKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      fifo_wr_en <= 1'b0;
      msg_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press_pulse) begin
            cap   <= data_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_SEND;
`ifdef TX_CHECKSUM_EN
            cksum <= '0;
`endif
          end
        end
        ST_SEND: begin
          if (!tx_fifo_full && !fifo_wr_en) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= frame_byte;
            idx        <= idx + 4'd1;
`ifdef TX_CHECKSUM_EN
            // Only the prefix and the two data characters feed the checksum.
            if (idx < 4'(PREFIX_LEN + 2)) cksum <= cksum ^ frame_byte;
`endif
            if (idx == LAST_IDX) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          msg_done <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_message_sequencer.sv
// Self-checking bench for tx_message_sequencer; the expected frame is built
// from formatted strings and compared byte-by-byte as the DUT writes.
module tb_tx_message_sequencer;
  import tx_seq_pkg::*;

  localparam int DB = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          btn = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic          tx_fifo_full = 1'b0;
  logic [7:0]    fifo_data;
  logic          fifo_wr_en;
  logic          busy;
  logic          msg_done;
  tx_seq_state_e state_dbg;

  int         vec_count = 0;
  int         err_count = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         wr_cnt = 0;
  int         frame_wr = 0;
  int         last_wr_cyc = -100;
  logic       prev_wr = 1'b0;
  logic       prev_full = 1'b0;
  logic [7:0] last_data = 8'h00;
  bit         check_gap = 1'b0;

  // clock / reset
  always #5 CLK = ~CLK;

  tx_message_sequencer #(
    .DATA_WIDTH     (8),
    .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .btn         (btn),
    .data_in     (data_in),
    .tx_fifo_full(tx_fifo_full),
    .fifo_data   (fifo_data),
    .fifo_wr_en  (fifo_wr_en),
    .busy        (busy),
    .msg_done    (msg_done),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the frame as text, then CR LF.
  task automatic push_frame(input logic [7:0] d);
    string s;
    string h;
`ifdef TX_CHECKSUM_EN
    logic [7:0] ck;
`endif
    h = $sformatf("%02x", d);
    s = {"DATA:", h.toupper()};
`ifdef TX_CHECKSUM_EN
    ck = 8'h00;
    for (int i = 0; i < s.len(); i++) ck = ck ^ s[i];
    h = $sformatf("%02x", ck);
    s = {s, h.toupper()};
`endif
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // One clock: scoreboard at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [8:0] exp9;
    @(negedge CLK);
    if (RST) begin
      if (fifo_wr_en) begin
        exp9 = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        check("fifo_data", {23'd0, 1'b0, fifo_data}, {23'd0, exp9});
        check("wr_busy", busy, 1);
        check("wr_while_full", prev_full, 0);
        check("wr_back_to_back", prev_wr, 0);
        if (check_gap && frame_wr > 0) check("wr_gap", cyc - last_wr_cyc, 2);
        frame_wr++;
        wr_cnt++;
        last_wr_cyc = cyc;
        last_data = fifo_data;
      end else begin
        check("data_hold", fifo_data, last_data);
      end
      if (msg_done) begin
        check("done_queue_empty", exp_q.size(), 0);
        check("done_busy_low", busy, 0);
        done_cnt++;
        frame_wr = 0;
      end
    end
    prev_wr = fifo_wr_en;
    prev_full = tx_fifo_full;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, input int hold, input int stall_pct,
                           input int stall_after, input int stall_len);
    int start;
    int stall_left;
    int w0;
    bit stalled;
    start = done_cnt;
    stall_left = -1;
    w0 = 0;
    stalled = 1'b0;
    data_in = d;
    push_frame(d);
    btn = 1'b0;
    for (int i = 0; i < hold + 600; i++) begin
      if (i == hold) btn = 1'b1;
      if (stall_after >= 0 && !stalled && frame_wr == stall_after) begin
        stalled = 1'b1;
        stall_left = stall_len;
        w0 = wr_cnt;
      end
      if (stall_left > 0) begin
        tx_fifo_full = 1'b1;
        stall_left--;
      end else begin
        if (stall_left == 0) begin
          check("stall_no_write", wr_cnt - w0, 0);
          stall_left = -1;
        end
        tx_fifo_full = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
      end
      tick();
      if (i > hold + DB + 4 && done_cnt != start) break;
    end
    tx_fifo_full = 1'b0;
    check("frame_done_count", done_cnt - start, 1);
    check("frame_residue", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int w0;
    int d0;
    logic [7:0] rd;

    // Reset state
    #12;
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_data", fifo_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", msg_done, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (5) tick();

    // 1. clean press, writes exactly two cycles apart
    check_gap = 1'b1;
    run_frame(8'h3C, 12, 0, -1, 0);
    check_gap = 1'b0;
    repeat (5) tick();

    // 2. glitch shorter than the debounce window, then a long hold
    w0 = wr_cnt;
    d0 = done_cnt;
    btn = 1'b0;
    repeat (5) tick();
    btn = 1'b1;
    repeat (30) tick();
    check("glitch_no_write", wr_cnt - w0, 0);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_busy", busy, 0);
    rd = 8'($urandom_range(0, 255));
    run_frame(rd, 1000, 0, -1, 0);
    repeat (15) tick();

    // 3. back-pressure after the third write
    run_frame(8'h3C, 12, 0, 3, 20);
    repeat (15) tick();

    // 4. second press while busy, data_in changed after capture
    w0 = wr_cnt;
    d0 = done_cnt;
    data_in = 8'h3C;
    push_frame(8'h3C);
    for (int i = 0; i < 400; i++) begin
      btn = !((i < 12) || (i >= 40 && i < 55));
      if (i == 30) data_in = 8'hFF;
      tx_fifo_full = (i >= 20 && i < 70);
      if (i == 60) check("busy_during_stall", busy, 1);
      tick();
      if (i > 80 && done_cnt != d0) break;
    end
    tx_fifo_full = 1'b0;
    btn = 1'b1;
    repeat (30) tick();
    check("busy_press_one_frame", done_cnt - d0, 1);
    check("busy_press_writes", wr_cnt - w0, exp_q.size() == 0 ? 9 : -1);
    exp_q.delete();
    run_frame(8'hFF, 12, 0, -1, 0);
    repeat (15) tick();

    // 5. asynchronous reset after the fourth write
    data_in = 8'h3C;
    push_frame(8'h3C);
    btn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 12) btn = 1'b1;
      tick();
      if (frame_wr == 4) break;
    end
    btn = 1'b1;
    check("pre_reset_writes", frame_wr, 4);
    #2;
    RST = 1'b0;
    #1;
    check("arst_wr_en", fifo_wr_en, 0);
    check("arst_data", fifo_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", msg_done, 0);
    check("arst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    frame_wr = 0;
    last_data = 8'h00;
    repeat (3) tick();
    RST = 1'b1;
    repeat (15) tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_state", state_dbg, ST_IDLE);
    run_frame(8'h3C, 12, 0, -1, 0);
    repeat (15) tick();

    // Randomized frames with random back-pressure
    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom_range(0, 255));
      run_frame(rd, $urandom_range(12, 40), $urandom_range(0, 60), -1, 0);
      repeat (15) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/tx_message_sequencer.md
Name: tx_message_sequencer

Overview:
Upstream feeder for the UART transmit path. It debounces the DE2 push-button and, on each accepted press, captures the 8-bit switch value. It then streams a fixed ASCII frame into the transmitter FIFO write port: prefix "DATA:", two uppercase hex characters of the captured byte, then CR LF. Writes honour FIFO back-pressure, so no byte is ever lost or duplicated.

Parameters:
DATA_WIDTH, 8, width of data_in and fifo_data; only 8 is supported.
DEBOUNCE_CYCLES, 500000, number of CLK cycles the synchronized button must be stable before a level change is accepted (10 ms at 50 MHz).
BTN_ACTIVE_LOW, 1, 1 = a pressed button reads as 0 (DE2 KEY); 0 = a pressed button reads as 1.

Ports:
CLK  input  1  system clock, 50 MHz
RST  input  1  asynchronous, active-low reset
btn  input  1  raw, asynchronous push-button
data_in  input  DATA_WIDTH  switch value, sampled on an accepted press
tx_fifo_full  input  1  transmitter FIFO full flag
fifo_data  output  DATA_WIDTH  byte to write into the FIFO; registered
fifo_wr_en  output  1  one-cycle FIFO write strobe; registered
busy  output  1  high while a frame is in progress
msg_done  output  1  one-cycle pulse after the last byte of a frame is written

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs go to 0.
  - FSM goes to IDLE; the byte index, debounce counter and checksum are cleared.
  - The synchronizer flops and the debounced level are set to "released".
- Reset mid-frame aborts the frame. Bytes already written stay in the FIFO.
- Button path:
  - 2-flop synchronizer, then polarity is normalised by BTN_ACTIVE_LOW.
  - Counter: the debounced level updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any match resets the counter.
  - press_pulse is a one-cycle pulse on each released-to-pressed transition of the debounced level. Holding the button gives exactly one pulse.
- FSM states: IDLE, SEND, DONE.
  - IDLE: on press_pulse, latch data_in into cap, set idx=0, go to SEND. busy=0 in IDLE.
  - SEND: a write is issued when tx_fifo_full==0 and fifo_wr_en==0 in the current cycle.
    - Issuing a write means: next cycle fifo_wr_en=1, fifo_data=frame[idx], idx increments.
    - Writes are therefore at most one every 2 cycles, which gives the FIFO's full flag one cycle to update.
    - When the last byte is issued, go to DONE.
  - DONE: msg_done=1 for exactly one cycle, then IDLE.
  - busy=1 in SEND and DONE.
- Latency: press_pulse in cycle N -> first fifo_wr_en in cycle N+2 if the FIFO is not full.
- Frame, 9 bytes: 0x44 0x41 0x54 0x41 0x3A, hex(cap[7:4]), hex(cap[3:0]), 0x0D, 0x0A.
- hex(n): n<10 gives 0x30+n; otherwise 0x41+(n-10).
- Back-pressure: while tx_fifo_full=1 no write is issued; idx and fifo_data hold. When full drops, the frame resumes at the same idx.
- A press_pulse while busy=1 is ignored and not queued. data_in changes after capture do not affect the frame.
- fifo_data keeps its last value when fifo_wr_en=0.

Optional Feature:
Macro TX_CHECKSUM_EN.
- Defined: frame is 11 bytes. The two checksum bytes are inserted before CR LF:
  - Checksum = XOR of all preceding frame bytes (prefix plus the two hex characters).
  - It is sent as two uppercase hex characters, upper nibble first.
  - The accumulator clears on entry to SEND.
- Undefined: 9-byte frame; no accumulator logic.

Decomposition:
- Shared package tx_seq_pkg holds:
  - state encoding (IDLE/SEND/DONE);
  - prefix byte constants and PREFIX_LEN=5;
  - ASCII_CR, ASCII_LF;
  - FRAME_LEN_BASE=9, FRAME_LEN_CKSUM=11;
  - nibble_to_hex function.
- One sub-module: button_debouncer (synchronizer, counter, press_pulse; parameters DEBOUNCE_CYCLES and BTN_ACTIVE_LOW). The FSM and frame mux stay in the top.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=8.)
1. Clean press, data_in=8'h3C, full=0 -> writes 44 41 54 41 3A 33 43 0D 0A, wr_en spaced 2 cycles apart, then a single msg_done pulse and busy=0.
2. Glitch: btn pressed for 5 cycles, then released -> no press_pulse and no fifo_wr_en. Button held for 1000 cycles -> exactly one frame.
3. tx_fifo_full=1 for 20 cycles after the 3rd write -> no wr_en during the stall. Resume order is exactly 41 3A ..., with no skipped or repeated byte.
4. Second press during busy, with data_in changed to 8'hFF mid-frame -> exactly one frame, carrying 33 43. After idle, a new press with 8'hFF gives 46 46.
5. RST asserted after the 4th write -> outputs go to 0 asynchronously. After release: idle, busy=0, and the next press sends a complete frame from 0x44.
6. TX_CHECKSUM_EN defined, data_in=8'h3C -> 44 41 54 41 3A 33 43 35 41 0D 0A (checksum 0x5A).
